fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter XLEN, default 64, PC and memory address width.
REQ-002 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch PC after reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 redirect_valid  input  1  flush fetch and restart at redirect_pc.
REQ-006 redirect_pc  input  XLEN  new fetch PC, 4-byte aligned.
REQ-007 imem_req_valid  output  1  instruction memory request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_req_addr  output  XLEN  request address, 8-byte aligned.
REQ-010 imem_resp_valid  input  1  64-bit fetch data returned, one cycle pulse, in order.
REQ-011 imem_resp_data  input  64  two instructions, [31:0] lower address.
REQ-012 fq_wr_en  output  1  push to downstream fetch queue.
REQ-013 fq_wr_data  output  FQ_ENTRY_W(=130)  {pc[63:0], inst1[31:0], inst0[31:0], valid[1:0]}.
REQ-014 fq_full  input  1  fetch queue full; push not accepted.
REQ-015 fq_clr  output  1  one-cycle pulse clearing the fetch queue.

Function
REQ-016 FSM states: REQ, WAIT, HOLD, DROP; at most one outstanding memory request.
REQ-017 REQ: imem_req_valid=1, imem_req_addr={pc[XLEN-1:3],3'b0}; on imem_req_ready go WAIT, else stay.
REQ-018 WAIT: on imem_resp_valid with fq_full=0, fq_wr_en=1 same cycle (zero-cycle response-to-push), pc <= {pc[XLEN-1:3],3'b0}+8, go REQ.
REQ-019 WAIT: on imem_resp_valid with fq_full=1, capture entry in hold register, go HOLD.
REQ-020 HOLD: fq_wr_en=1 from hold register whenever fq_full=0, then advance pc per REQ-018, go REQ.
REQ-021 Entry: pc = fetch pc; inst0/inst1 = resp_data low/high; valid=2'b11 if pc[2]=0, 2'b10 if pc[2]=1.
REQ-022 fq_wr_en SHALL never assert while fq_full=1.
REQ-023 redirect_valid: fq_clr=1 same cycle, pc <= redirect_pc, fq_wr_en forced 0 that cycle.
REQ-024 Redirect in REQ without handshake, or in HOLD: hold entry discarded, go REQ.
REQ-025 Redirect in REQ with imem_req_ready=1 same cycle, or in WAIT without response: go DROP.
REQ-026 Redirect in WAIT coincident with imem_resp_valid: response discarded, go REQ.
REQ-027 DROP: imem_req_valid=0; next imem_resp_valid discarded, go REQ; redirect in DROP updates pc, stays DROP unless response same cycle (then REQ).
REQ-028 PC wraps modulo 2^XLEN; no exception on wrap.
REQ-029 imem_req_addr and pc stable while imem_req_valid=1 and imem_req_ready=0, absent redirect.

Reset
REQ-030 rst_n=0: state=REQ, pc=RESET_PC, hold register cleared.
REQ-031 Outputs imem_req_valid, fq_wr_en, fq_clr = 0 while rst_n=0 (gated by rst_n).
REQ-032 Reset mid-operation abandons any outstanding request; memory side is reset concurrently, no DROP needed.
REQ-033 First cycle after rst_n release: imem_req_valid=1, imem_req_addr=RESET_PC aligned.

Structure
REQ-034 fetch_pkg holds fetch_entry_t packed struct, FQ_ENTRY_W, fetch_state_e enum; shared with sync_fifo instantiation at parent (WIDTH=FQ_ENTRY_W).
REQ-035 Single module, no sub-modules; parent connects fq_* to sync_fifo wr_en/wr_data/full/clr.

Verification
REQ-036 Reset release, ready=1, response 2 cycles later data=64'hBBBB_BBBB_AAAA_AAAA -> push pc=0x8000_0000, inst0=AAAA_AAAA, inst1=BBBB_BBBB, valid=11; next addr 0x8000_0008.
REQ-037 redirect_pc=0x1004 -> fq_clr pulse, next req addr 0x1000, pushed entry valid=10, then addr 0x1008.
REQ-038 fq_full=1 at response -> HOLD, no push; fq_full drops 3 cycles later -> single push same data.
REQ-039 Redirect in WAIT, response next cycle -> response not pushed, new req issued cycle after; coincident redirect+response -> no push, REQ next cycle.
REQ-040 Redirect while req_valid=1, ready=1 same cycle -> DROP; stale response discarded; next req addr = redirect_pc aligned.
REQ-041 pc=0xFFFF_FFFF_FFFF_FFF8 fetch -> next req addr 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Types shared by the fetch stage and the fetch-queue instantiation at the parent.
package fetch_pkg;

  localparam int FQ_ENTRY_W = 130;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst1;
    logic [31:0] inst0;
    logic [1:0]  valid;
  } fetch_entry_t;

  // A fetch starting at the upper word of a line carries only one useful slot.
  function automatic logic [1:0] slot_valid(input logic pc_bit2);
    return pc_bit2 ? 2'b10 : 2'b11;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding 8-byte line request, pushes two-instruction
// entries into the fetch queue, with redirect/flush and stale-response dropping.
import fetch_pkg::*;

module fetch_stage #(
  parameter int                XLEN     = 64,
  parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [XLEN-1:0]       imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [63:0]           imem_resp_data,
  output logic                  fq_wr_en,
  output logic [FQ_ENTRY_W-1:0] fq_wr_data,
  input  logic                  fq_full,
  output logic                  fq_clr,
  output fetch_state_e          dbg_state
);

  // Handshake: a request transfers on a cycle where imem_req_valid and
  // imem_req_ready are both 1; a push transfers whenever fq_wr_en is 1, and
  // fq_wr_en is only raised while fq_full is 0.

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  fetch_entry_t    r_hold;

  logic [XLEN-1:0] w_pc_aligned;
  logic [XLEN-1:0] w_pc_next;
  fetch_entry_t    w_entry;
  logic            w_push_resp;
  logic            w_push_hold;

  assign w_pc_aligned = {r_pc[XLEN-1:3], 3'b000};
  assign w_pc_next    = w_pc_aligned + XLEN'(8);

  always_comb begin
    w_entry       = '0;
    w_entry.pc    = 64'(r_pc);
    w_entry.inst1 = imem_resp_data[63:32];
    w_entry.inst0 = imem_resp_data[31:0];
    w_entry.valid = slot_valid(r_pc[2]);
  end

  // Redirect suppresses any push in the same cycle, since the queue is being cleared.
  assign w_push_resp = (r_state == S_WAIT) && imem_resp_valid && !fq_full && !redirect_valid;
  assign w_push_hold = (r_state == S_HOLD) && !fq_full && !redirect_valid;

  assign imem_req_valid = rst_n && (r_state == S_REQ);
  assign imem_req_addr  = w_pc_aligned;
  assign fq_wr_en       = rst_n && (w_push_resp || w_push_hold);
  assign fq_wr_data     = (r_state == S_HOLD) ? r_hold : w_entry;
  assign fq_clr         = rst_n && redirect_valid;
  assign dbg_state      = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_hold  <= '0;
    end else if (redirect_valid) begin
      r_pc   <= redirect_pc;
      r_hold <= '0;
      // A request already in flight must have its response swallowed in DROP.
      case (r_state)
        S_REQ:   r_state <= imem_req_ready ? S_DROP : S_REQ;
        S_WAIT:  r_state <= imem_resp_valid ? S_REQ : S_DROP;
        S_HOLD:  r_state <= S_REQ;
        S_DROP:  r_state <= imem_resp_valid ? S_REQ : S_DROP;
        default: r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (!fq_full) begin
              r_pc    <= w_pc_next;
              r_state <= S_REQ;
            end else begin
              r_hold  <= w_entry;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!fq_full) begin
            r_pc    <= w_pc_next;
            r_hold  <= '0;
            r_state <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_resp_valid) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed addresses and queue entries.
import fetch_pkg::*;

module tb_fetch_stage;

  logic                  clk;
  logic                  rst_n;
  logic                  redirect_valid;
  logic [63:0]           redirect_pc;
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [63:0]           imem_req_addr;
  logic                  imem_resp_valid;
  logic [63:0]           imem_resp_data;
  logic                  fq_wr_en;
  logic [FQ_ENTRY_W-1:0] fq_wr_data;
  logic                  fq_full;
  logic                  fq_clr;
  fetch_state_e          dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .fq_wr_en        (fq_wr_en),
    .fq_wr_data      (fq_wr_data),
    .fq_full         (fq_full),
    .fq_clr          (fq_clr),
    .dbg_state       (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [129:0] mk_entry(input logic [63:0] pc, input logic [63:0] data,
                                            input logic [1:0] v);
    return {pc, data[63:32], data[31:0], v};
  endfunction

  task automatic idle_inputs();
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    fq_full         = 1'b0;
  endtask

  initial begin
    redirect_pc    = 64'h0;
    imem_resp_data = 64'h0;

    // Reset with every input active: outputs must stay gated.
    rst_n = 1'b0;
    redirect_valid = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b1; fq_full = 1'b0;
    tick(); tick();
    check("rst_req_valid", 130'(imem_req_valid), 130'(0));
    check("rst_wr_en",     130'(fq_wr_en), 130'(0));
    check("rst_clr",       130'(fq_clr), 130'(0));
    check("rst_state",     130'(dbg_state), 130'(S_REQ));

    // First fetch after release.
    idle_inputs();
    rst_n = 1'b1;
    settle();
    check("first_req_valid", 130'(imem_req_valid), 130'(1));
    check("first_req_addr",  130'(imem_req_addr), 130'(64'h8000_0000));
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    settle();
    check("wait_no_req", 130'(imem_req_valid), 130'(0));
    check("wait_no_push", 130'(fq_wr_en), 130'(0));
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 64'hBBBB_BBBB_AAAA_AAAA;
    settle();
    check("resp_push", 130'(fq_wr_en), 130'(1));
    check("resp_entry", fq_wr_data, mk_entry(64'h8000_0000, 64'hBBBB_BBBB_AAAA_AAAA, 2'b11));
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check("next_addr", 130'(imem_req_addr), 130'(64'h8000_0008));
    check("next_req_valid", 130'(imem_req_valid), 130'(1));

    // Address holds while memory stalls.
    tick();
    check("stall_addr", 130'(imem_req_addr), 130'(64'h8000_0008));
    check("stall_state", 130'(dbg_state), 130'(S_REQ));

    // Redirect in REQ without handshake to an odd-word PC.
    redirect_valid = 1'b1; redirect_pc = 64'h1004;
    settle();
    check("redir_clr", 130'(fq_clr), 130'(1));
    tick();
    redirect_valid = 1'b0;
    settle();
    check("redir_clr_pulse", 130'(fq_clr), 130'(0));
    check("redir_addr", 130'(imem_req_addr), 130'(64'h1000));
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 64'h2222_2222_1111_1111;
    settle();
    check("half_push", 130'(fq_wr_en), 130'(1));
    check("half_entry", fq_wr_data, mk_entry(64'h1004, 64'h2222_2222_1111_1111, 2'b10));
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check("half_next_addr", 130'(imem_req_addr), 130'(64'h1008));

    // Queue full at response: hold, then a single push when space opens.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 64'h4444_4444_3333_3333; fq_full = 1'b1;
    settle();
    check("full_no_push", 130'(fq_wr_en), 130'(0));
    tick();
    imem_resp_valid = 1'b0; imem_resp_data = 64'h0;
    settle();
    check("hold_state", 130'(dbg_state), 130'(S_HOLD));
    check("hold_no_push1", 130'(fq_wr_en), 130'(0));
    tick();
    check("hold_no_push2", 130'(fq_wr_en), 130'(0));
    tick();
    check("hold_no_push3", 130'(fq_wr_en), 130'(0));
    fq_full = 1'b0;
    settle();
    check("hold_push", 130'(fq_wr_en), 130'(1));
    check("hold_entry", fq_wr_data, mk_entry(64'h1008, 64'h4444_4444_3333_3333, 2'b11));
    tick();
    check("hold_single_push", 130'(fq_wr_en), 130'(0));
    check("hold_next_addr", 130'(imem_req_addr), 130'(64'h1010));

    // Redirect in WAIT, stale response next cycle.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    settle();
    check("wredir_clr", 130'(fq_clr), 130'(1));
    tick();
    redirect_valid = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 64'hDEAD_DEAD_DEAD_DEAD;
    settle();
    check("drop_state", 130'(dbg_state), 130'(S_DROP));
    check("drop_no_push", 130'(fq_wr_en), 130'(0));
    check("drop_no_req", 130'(imem_req_valid), 130'(0));
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check("after_drop_req", 130'(imem_req_valid), 130'(1));
    check("after_drop_addr", 130'(imem_req_addr), 130'(64'h2000));

    // Redirect coincident with response in WAIT.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h3000;
    imem_resp_valid = 1'b1; imem_resp_data = 64'h5555_5555_5555_5555;
    settle();
    check("coinc_no_push", 130'(fq_wr_en), 130'(0));
    check("coinc_clr", 130'(fq_clr), 130'(1));
    tick();
    redirect_valid = 1'b0; imem_resp_valid = 1'b0;
    settle();
    check("coinc_state", 130'(dbg_state), 130'(S_REQ));
    check("coinc_addr", 130'(imem_req_addr), 130'(64'h3000));

    // Redirect with handshake in REQ, then redirect again while in DROP.
    redirect_valid = 1'b1; redirect_pc = 64'h400C; imem_req_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b0;
    settle();
    check("hs_drop_state", 130'(dbg_state), 130'(S_DROP));
    check("hs_drop_no_req", 130'(imem_req_valid), 130'(0));
    redirect_valid = 1'b1; redirect_pc = 64'h5000;
    tick();
    redirect_valid = 1'b0;
    settle();
    check("drop_redir_state", 130'(dbg_state), 130'(S_DROP));
    imem_resp_valid = 1'b1; imem_resp_data = 64'h6666_6666_6666_6666;
    settle();
    check("stale_no_push", 130'(fq_wr_en), 130'(0));
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check("drop_redir_addr", 130'(imem_req_addr), 130'(64'h5000));

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    settle();
    check("top_addr", 130'(imem_req_addr), 130'(64'hFFFF_FFFF_FFFF_FFF8));
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 64'h8888_8888_7777_7777;
    settle();
    check("top_entry", fq_wr_data, mk_entry(64'hFFFF_FFFF_FFFF_FFF8, 64'h8888_8888_7777_7777, 2'b11));
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check("wrap_addr", 130'(imem_req_addr), 130'(64'h0));

    // Redirect in HOLD discards the held entry.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 64'h9999_9999_9999_9999; fq_full = 1'b1;
    tick();
    imem_resp_valid = 1'b0; fq_full = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h6000;
    settle();
    check("hredir_no_push", 130'(fq_wr_en), 130'(0));
    check("hredir_clr", 130'(fq_clr), 130'(1));
    tick();
    redirect_valid = 1'b0;
    settle();
    check("hredir_state", 130'(dbg_state), 130'(S_REQ));
    check("hredir_addr", 130'(imem_req_addr), 130'(64'h6000));
    check("hredir_no_late_push", 130'(fq_wr_en), 130'(0));

    // Reset while a request is outstanding.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    settle();
    check("mid_rst_gate", 130'(imem_req_valid), 130'(0));
    tick();
    rst_n = 1'b1;
    settle();
    check("mid_rst_state", 130'(dbg_state), 130'(S_REQ));
    check("mid_rst_addr", 130'(imem_req_addr), 130'(64'h8000_0000));
    check("mid_rst_req", 130'(imem_req_valid), 130'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
